// File: rtl/uart_alu_ctrl.sv
// Sequencer between a UART rx/tx pair and a combinational ALU: collects A, B, opcode,
// latches the ALU result (or an error byte) and hands it to the transmitter.
module uart_alu_ctrl #(
   parameter int unsigned NB_DATA       = 8,
   parameter int unsigned NB_OP         = 6,
   parameter int unsigned TIMEOUT_TICKS = 640,
   parameter logic [NB_DATA-1:0] ERR_CODE = NB_DATA'(8'hEE)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_s_tick,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done_tick,
   input  logic               i_tx_done_tick,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic [NB_DATA-1:0] o_alu_a,
   output logic [NB_DATA-1:0] o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_error,
   output logic               o_timeout,
   output logic               o_overrun
);

   localparam int unsigned NB_CNT = $clog2(TIMEOUT_TICKS);
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;

   state_t            state;
   logic [NB_CNT-1:0] tick_cnt;
   logic              op_valid_c;

   // Opcode decode against the ALU's supported operation set
   always_comb begin
      op_valid_c = 1'b0;
      case (o_alu_op)
         NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
         NB_OP'(6'b100110), NB_OP'(6'b100111), NB_OP'(6'b000011), NB_OP'(6'b000010):
            op_valid_c = 1'b1;
         default: op_valid_c = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         o_alu_a    <= '0;
         o_alu_b    <= '0;
         o_alu_op   <= '0;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
         o_busy     <= 1'b0;
         o_error    <= 1'b0;
         o_timeout  <= 1'b0;
         o_overrun  <= 1'b0;
      end else begin
         o_tx_start <= 1'b0;
         o_error    <= 1'b0;
         o_timeout  <= 1'b0;
         o_overrun  <= 1'b0;
         case (state)
            IDLE: begin
               if (i_rx_done_tick) begin
                  o_alu_a  <= i_rx_data;
                  tick_cnt <= '0;
                  state    <= WAIT_B;
                  o_busy   <= 1'b1;
               end
            end
            WAIT_B, WAIT_OP: begin
               // A received byte takes priority over an expiring timeout
               if (i_rx_done_tick) begin
                  tick_cnt <= '0;
                  if (state == WAIT_B) begin
                     o_alu_b <= i_rx_data;
                     state   <= WAIT_OP;
                  end else begin
                     o_alu_op <= i_rx_data[NB_OP-1:0];
                     state    <= EXEC;
                  end
               end else if (i_s_tick) begin
                  if (tick_cnt == CNT_LAST) begin
                     o_timeout <= 1'b1;
                     tick_cnt  <= '0;
                     state     <= IDLE;
                     o_busy    <= 1'b0;
                  end else begin
                     tick_cnt <= tick_cnt + NB_CNT'(1);
                  end
               end
            end
            EXEC: begin
               o_tx_data  <= op_valid_c ? i_alu_result : ERR_CODE;
               o_error    <= ~op_valid_c;
               o_tx_start <= 1'b1;
               state      <= SEND;
            end
            SEND: begin
               state <= WAIT_TX;
            end
            WAIT_TX: begin
               if (i_tx_done_tick) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
         // Bytes arriving while a result is in flight are dropped and flagged
         if (i_rx_done_tick && (state == EXEC || state == SEND || state == WAIT_TX))
            o_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: frame-level reference model compared every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_uart_alu_ctrl;

   localparam int unsigned TOUT = 640;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_tick = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_done = 1'b0;
   logic       tx_done = 1'b0;
   logic [7:0] alu_res;
   logic [7:0] o_alu_a, o_alu_b, o_tx_data;
   logic [5:0] o_alu_op;
   logic       o_tx_start, o_busy, o_error, o_timeout, o_overrun;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

   always #5 clk = ~clk;

   uart_alu_ctrl dut (
      .i_clk(clk), .i_reset(rst), .i_s_tick(s_tick), .i_rx_data(rx_data),
      .i_rx_done_tick(rx_done), .i_tx_done_tick(tx_done), .i_alu_result(alu_res),
      .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_tx_data(o_tx_data),
      .o_tx_start(o_tx_start), .o_busy(o_busy), .o_error(o_error),
      .o_timeout(o_timeout), .o_overrun(o_overrun)
   );

   function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h03:   return 8'($signed(a) >>> b);
         6'h02:   return a >> b;
         default: return 8'h00;
      endcase
   endfunction

   function automatic bit op_ok(input logic [5:0] op);
      return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
   endfunction

   assign alu_res = alu(o_alu_a, o_alu_b, o_alu_op);

   // Reference model: bytes collected so far, idle ticks since last byte, age of the response
   logic [7:0] m_a, m_b, m_tx;
   logic [5:0] m_op;
   logic       m_start, m_err, m_to, m_ovr;
   int         nbytes, idle_ticks, age;
   bit         in_resp;
   logic       m_busy;
   assign m_busy = in_resp || (nbytes != 0);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_a <= '0; m_b <= '0; m_op <= '0; m_tx <= '0;
         m_start <= 1'b0; m_err <= 1'b0; m_to <= 1'b0; m_ovr <= 1'b0;
         nbytes <= 0; idle_ticks <= 0; age <= 0; in_resp <= 1'b0;
      end else begin
         m_start <= 1'b0; m_err <= 1'b0; m_to <= 1'b0; m_ovr <= 1'b0;
         if (in_resp) begin
            m_ovr <= rx_done;
            age   <= age + 1;
            if (age == 0) begin
               m_tx    <= op_ok(m_op) ? alu(m_a, m_b, m_op) : 8'hEE;
               m_err   <= !op_ok(m_op);
               m_start <= 1'b1;
            end
            if (age >= 2 && tx_done) in_resp <= 1'b0;
         end else if (rx_done) begin
            case (nbytes)
               0:       m_a  <= rx_data;
               1:       m_b  <= rx_data;
               default: m_op <= rx_data[5:0];
            endcase
            if (nbytes == 2) begin
               nbytes <= 0; in_resp <= 1'b1; age <= 0;
            end else begin
               nbytes <= nbytes + 1;
            end
            idle_ticks <= 0;
         end else if (nbytes > 0 && s_tick) begin
            if (idle_ticks + 1 == TOUT) begin
               m_to <= 1'b1; nbytes <= 0; idle_ticks <= 0;
            end else begin
               idle_ticks <= idle_ticks + 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("alu_a", 32'(o_alu_a), 32'(m_a));
      check("alu_b", 32'(o_alu_b), 32'(m_b));
      check("alu_op", 32'(o_alu_op), 32'(m_op));
      check("tx_data", 32'(o_tx_data), 32'(m_tx));
      check("tx_start", 32'(o_tx_start), 32'(m_start));
      check("busy", 32'(o_busy), 32'(m_busy));
      check("error", 32'(o_error), 32'(m_err));
      check("timeout", 32'(o_timeout), 32'(m_to));
      check("overrun", 32'(o_overrun), 32'(m_ovr));
   endtask

   // One clock: compare outputs against the model, then drive this cycle's inputs
   task automatic cyc(input logic t, input logic r, input logic [7:0] d, input logic td);
      @(negedge clk);
      if (chk_en) compare_all();
      s_tick = t; rx_done = r; rx_data = d; tx_done = td;
   endtask

   task automatic send_byte(input logic [7:0] d);
      cyc(1'b0, 1'b1, d, 1'b0);
   endtask

   task automatic finish_frame(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                               input logic [7:0] exp_tx, input logic exp_err, input bit ovr);
      int lat;
      lat = -1;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0, 8'h00, 1'b0);
         if (o_tx_start) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         check("tx_start_seen", 32'd0, 32'd1);
         return;
      end
      check("latency", 32'(lat), 32'd1);
      check("lit_tx", 32'(o_tx_data), 32'(exp_tx));
      check("model_tx", 32'(m_tx), 32'(exp_tx));
      check("lit_err", 32'(o_error), 32'(exp_err));
      check("lit_a", 32'(o_alu_a), 32'(a));
      check("lit_b", 32'(o_alu_b), 32'(b));
      check("lit_op", 32'(o_alu_op), 32'(op));
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      if (ovr) begin
         cyc(1'b0, 1'b1, 8'h55, 1'b0);
         cyc(1'b0, 1'b0, 8'h00, 1'b0);
         check("lit_overrun", 32'(o_overrun), 32'd1);
         check("lit_tx_held", 32'(o_tx_data), 32'(exp_tx));
      end
      check("lit_busy_wait", 32'(o_busy), 32'd1);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      check("lit_busy_done", 32'(o_busy), 32'd0);
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] exp_tx, input logic exp_err, input bit ovr);
      send_byte(a);
      send_byte(b);
      send_byte(op);
      finish_frame(a, b, op[5:0], exp_tx, exp_err, ovr);
   endtask

   initial begin
      logic [7:0] d;
      logic       t, r, td;
      #12 rst = 1'b0;
      chk_en = 1'b1;
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_tx_data", 32'(o_tx_data), 32'd0);
      check("rst_alu_a", 32'(o_alu_a), 32'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);

      // Reset mid-frame, then a fresh frame
      send_byte(8'h05);
      send_byte(8'h03);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      check("busy_before_rst", 32'(o_busy), 32'd1);
      #2 rst = 1'b1;
      #1 check("busy_async_rst", 32'(o_busy), 32'd0);
      check("alu_a_async_rst", 32'(o_alu_a), 32'd0);
      #1 rst = 1'b0;
      frame(8'h01, 8'h01, 8'h20, 8'h02, 1'b0, 1'b0);

      frame(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 1'b0);
      frame(8'hF0, 8'h0F, 8'h22, 8'hE1, 1'b0, 1'b0);
      frame(8'h80, 8'h02, 8'h03, 8'hE0, 1'b0, 1'b0);
      frame(8'h11, 8'h22, 8'h3F, 8'hEE, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      check("error_one_cycle", 32'(o_error), 32'd0);

      // Inter-byte timeout after operand A only
      send_byte(8'h07);
      for (int i = 0; i < int'(TOUT); i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      check("lit_timeout", 32'(o_timeout), 32'd1);
      check("lit_timeout_idle", 32'(o_busy), 32'd0);
      check("lit_timeout_keep_a", 32'(o_alu_a), 32'h07);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      check("timeout_one_cycle", 32'(o_timeout), 32'd0);
      frame(8'h01, 8'h02, 8'h20, 8'h03, 1'b0, 1'b0);

      // Byte coinciding with the final tick is accepted
      send_byte(8'h09);
      for (int i = 0; i < int'(TOUT) - 1; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 1'b1, 8'h04, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      check("race_no_timeout", 32'(o_timeout), 32'd0);
      check("race_busy", 32'(o_busy), 32'd1);
      send_byte(8'h20);
      finish_frame(8'h09, 8'h04, 6'h20, 8'h0D, 1'b0, 1'b0);

      // Overrun during transmission, then a clean frame
      frame(8'h0A, 8'h05, 8'h22, 8'h05, 1'b0, 1'b1);
      frame(8'h0C, 8'h0A, 8'h24, 8'h08, 1'b0, 1'b0);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         d  = 8'($urandom);
         if ($urandom_range(0, 3) != 0) d[5:0] = ops[$urandom_range(0, 7)];
         t  = ($urandom_range(0, 3) == 0);
         r  = ($urandom_range(0, 5) == 0);
         td = ($urandom_range(0, 4) == 0);
         cyc(t, r, d, td);
      end
      for (int n = 0; n < 4; n++) cyc(1'b0, 1'b0, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
